// File: rtl/led_pwm_fader.sv
// 12-channel LED brightness fader: per-LED saturating ramps toward 0/255, rendered by a
// shared 8-bit PWM counter, with a registered all-channels-settled flag.
module led_pwm_fader #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned FADE_DIV   = 4096,
  parameter int unsigned PWM_DIV    = 1,
  parameter int unsigned STEP       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pattern_in,
  output logic [11:0] led_out,
  output logic        settled
);

  localparam int unsigned FadeW    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int unsigned PwmW     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [FadeW-1:0] FadeLast = FadeW'(FADE_DIV - 1);
  localparam logic [PwmW-1:0]  PwmLast  = PwmW'(PWM_DIV - 1);
  localparam logic [8:0]  Step9   = 9'(STEP);
  localparam logic [11:0] OffCode = ACTIVE_LOW ? 12'hFFF : 12'h000;

  logic [11:0]      pat_q;
  logic [FadeW-1:0] fade_cnt_q, fade_cnt_d;
  logic [PwmW-1:0]  pwm_div_cnt_q, pwm_div_cnt_d;
  logic [7:0]       pwm_cnt_q, pwm_cnt_d;
  logic [7:0]       level_q [12];
  logic [7:0]       level_d [12];
  logic [11:0]      lit_q, lit_d;
  logic             settled_q, settled_d;
  logic [11:0]      on_vec;
  logic             fade_tick;
  logic             pwm_step;

  assign on_vec = ACTIVE_LOW ? ~pat_q : pat_q;

  always_comb begin
    fade_tick     = (fade_cnt_q == FadeLast);
    fade_cnt_d    = fade_tick ? '0 : fade_cnt_q + 1'b1;
    pwm_step      = (pwm_div_cnt_q == PwmLast);
    pwm_div_cnt_d = pwm_step ? '0 : pwm_div_cnt_q + 1'b1;
    pwm_cnt_d     = pwm_step ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    settled_d     = 1'b1;
    lit_d         = '0;
    for (int i = 0; i < 12; i++) begin
      logic [8:0] up;
      // 9-bit sum so the carry flags saturation at 255
      up         = {1'b0, level_q[i]} + Step9;
      level_d[i] = level_q[i];
      if (fade_tick) begin
        if (on_vec[i]) begin
          level_d[i] = up[8] ? 8'hFF : up[7:0];
        end else begin
          level_d[i] = (level_q[i] >= Step9[7:0]) ? level_q[i] - Step9[7:0] : 8'h00;
        end
      end
      lit_d[i] = (level_q[i] > pwm_cnt_q);
      if (level_q[i] != (on_vec[i] ? 8'hFF : 8'h00)) settled_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q         <= OffCode;
      fade_cnt_q    <= '0;
      pwm_div_cnt_q <= '0;
      pwm_cnt_q     <= '0;
      level_q       <= '{default: 8'h00};
      lit_q         <= '0;
      settled_q     <= 1'b1;
    end else begin
      pat_q         <= pattern_in;
      fade_cnt_q    <= fade_cnt_d;
      pwm_div_cnt_q <= pwm_div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      level_q       <= level_d;
      lit_q         <= lit_d;
      settled_q     <= settled_d;
    end
  end

  assign led_out = ACTIVE_LOW ? ~lit_q : lit_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: cycle-count based reference model checked every cycle, plus
// directed ramp/duty/reversal/reset scenarios and a randomized pattern phase.
module tb_led_pwm_fader;

  localparam int FadeDiv = 4;
  localparam int PwmDiv  = 1;
  localparam int Step    = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pattern_in;
  logic [11:0] led_out;
  logic        settled;

  int checks   = 0;
  int failures = 0;

  led_pwm_fader #(
    .ACTIVE_LOW(1'b1),
    .FADE_DIV  (FadeDiv),
    .PWM_DIV   (PwmDiv),
    .STEP      (Step)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pattern_in(pattern_in),
    .led_out   (led_out),
    .settled   (settled)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: level per channel, cycles since reset drive both timebases.
  int          m_lvl [12];
  logic [11:0] m_pat;
  logic [11:0] m_led;
  logic        m_set;
  bit          m_valid = 1'b0;
  int          n;
  int          q0[$];

  always begin
    @(negedge clk);
    if (m_valid) begin
      check("led_out", {20'h0, led_out}, {20'h0, m_led});
      check("settled", {31'h0, settled}, {31'h0, m_set});
    end
    if (rst) begin
      m_valid = 1'b1;
      m_pat   = 12'hFFF;
      m_led   = 12'hFFF;
      m_set   = 1'b1;
      n       = 0;
      for (int i = 0; i < 12; i++) m_lvl[i] = 0;
      q0.delete();
    end else if (m_valid) begin
      int  pwm;
      bit  tick;
      bit  all_ok;
      pwm    = (n / PwmDiv) % 256;
      tick   = (n % FadeDiv) == FadeDiv - 1;
      all_ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
        int tgt;
        tgt = m_pat[i] ? 0 : 255;
        if (m_lvl[i] != tgt) all_ok = 1'b0;
        m_led[i] = !(m_lvl[i] > pwm);
      end
      m_set = all_ok;
      if (tick) begin
        for (int i = 0; i < 12; i++) begin
          int nl;
          if (!m_pat[i]) nl = (m_lvl[i] + Step > 255) ? 255 : m_lvl[i] + Step;
          else           nl = (m_lvl[i] - Step < 0) ? 0 : m_lvl[i] - Step;
          if (i == 0 && nl != m_lvl[i]) q0.push_back(nl);
          m_lvl[i] = nl;
        end
      end
      m_pat = pattern_in;
      n++;
    end
  end

  task automatic cyc(input int k = 1);
    for (int j = 0; j < k; j++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_q0(input string name, input int exp[$]);
    check({name, "_len"}, q0.size(), exp.size());
    for (int j = 0; j < exp.size() && j < q0.size(); j++) check(name, q0[j], exp[j]);
  endtask

  task automatic wait_q0_128(input string name);
    bit hit;
    hit = 1'b0;
    for (int j = 0; j < 100 && !hit; j++) begin
      cyc();
      if (q0.size() > 0 && q0[$] == 128) hit = 1'b1;
    end
    check({name, "_reached128"}, {31'h0, hit}, 32'd1);
  endtask

  initial begin
    int dark;
    int others;
    rst        = 1'b1;
    pattern_in = 12'hFFF;
    cyc(2);
    check("reset_led", {20'h0, led_out}, 32'hFFF);
    check("reset_settled", {31'h0, settled}, 32'd1);
    rst = 1'b0;
    cyc(3);

    // Ramp up channel 0
    q0.delete();
    pattern_in = 12'hFFE;
    cyc(24);
    check_q0("ramp_up", '{64, 128, 192, 255});
    check("ramp_up_settled", {31'h0, settled}, 32'd1);

    // Duty at full brightness over one PWM period
    dark   = 0;
    others = 0;
    for (int j = 0; j < 256; j++) begin
      cyc();
      if (led_out[0] == 1'b0) dark++;
      if (led_out[11:1] != 11'h7FF) others++;
    end
    check("duty255", dark, 255);
    check("duty_others_off", others, 0);

    // Ramp down
    q0.delete();
    pattern_in = 12'hFFF;
    cyc(24);
    check_q0("ramp_down", '{191, 127, 63, 0});
    check("ramp_down_settled", {31'h0, settled}, 32'd1);

    // Reversal mid-ramp
    q0.delete();
    pattern_in = 12'h000;
    wait_q0_128("reversal");
    q0.delete();
    pattern_in = 12'hFFF;
    cyc(16);
    check_q0("reversal", '{64, 0});

    // Reset mid-fade
    q0.delete();
    pattern_in = 12'h000;
    wait_q0_128("midreset");
    rst = 1'b1;
    cyc();
    check("midreset_led", {20'h0, led_out}, 32'hFFF);
    check("midreset_settled", {31'h0, settled}, 32'd1);
    cyc(3);
    rst = 1'b0;
    cyc(24);
    check_q0("restart", '{64, 128, 192, 255});

    // Randomized patterns with occasional resets
    for (int j = 0; j < 600; j++) begin
      pattern_in = 12'($urandom);
      rst        = ($urandom_range(0, 60) == 0);
      cyc($urandom_range(1, 12));
      rst = 1'b0;
    end
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
